// File: rtl/rot_shift_sequencer.sv
// Multi-cycle shift/rotate unit: moves an operand at most MAX_STEP bit positions per clock
// through a narrow step stage and completes with a start/busy/done handshake.
module rot_shift_sequencer #(
    parameter int unsigned MAX_STEP = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    localparam logic [2:0] OP_SHR = 3'b000;
    localparam logic [2:0] OP_SRA = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;

    logic [CNT_W-1:0]    step_c;
    logic [DATA_W-1:0]   acc_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [2*DATA_W-1:0] dbl_r_c;
    logic [2*DATA_W-1:0] dbl_l_c;
    logic                no_run_c;
    logic                unused_b_c;

    // Upper distance bits carry no meaning: rotates and shifts are taken modulo 32.
    assign unused_b_c = ^b_in[31:5];

    // Zero distance and reserved opcodes skip RUN and return the operand unchanged.
    assign no_run_c = (b_in[4:0] == '0) || (op > OP_ROL);

    // One step of at most MAX_STEP positions applied to the accumulator.
    always_comb begin
        step_c  = (cnt_q > CNT_W'(MAX_STEP)) ? CNT_W'(MAX_STEP) : cnt_q;
        dbl_r_c = {acc_q, acc_q} >> step_c;
        dbl_l_c = {acc_q, acc_q} << step_c;
        acc_d   = acc_q;
        case (op_q)
            OP_SHR:  acc_d = acc_q >> step_c;
            OP_SRA:  acc_d = DATA_W'($signed(acc_q) >>> step_c);
            OP_SHL:  acc_d = acc_q << step_c;
            OP_ROR:  acc_d = dbl_r_c[DATA_W-1:0];
            OP_ROL:  acc_d = dbl_l_c[2*DATA_W-1:DATA_W];
            default: acc_d = acc_q;
        endcase
        cnt_d = cnt_q - step_c;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc_q <= a_in;
                        cnt_q <= b_in[4:0];
                        op_q  <= op;
                        if (no_run_c) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                            result  <= a_in;
                        end else begin
                            state_q <= S_RUN;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= acc_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
